// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared types and constants for the instruction fetch stage.
//   ifu_state_e    - fetch FSM state encoding (2-bit)
//   IFU_RESET_PC   - default PC loaded on reset
//   INST_NOP_WORD  - word shown on inst_o before any fetch (addi x0,x0,0)
//   PC_STEP        - sequential PC increment in bytes
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] INST_NOP_WORD = 32'h0000_0013;
  localparam int unsigned PC_STEP       = 4;

endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: fetch-stage signal bundle.
//   redirect_*   - next-PC override from branch/jump resolution
//   imem_req_*   - instruction memory read request (valid/ready)
//   imem_resp_*  - instruction memory read response
//   valid_o/ready_i/pc_o/inst_o - handshake toward decode
// Modports: master = fetch unit, slave = surrounding core/memory.
interface ifu_fetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              redirect_valid_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              imem_req_valid_o;
  logic [ADDR_W-1:0] imem_req_addr_o;
  logic              imem_req_ready_i;
  logic              imem_resp_valid_i;
  logic [DATA_W-1:0] imem_resp_data_i;
  logic              valid_o;
  logic              ready_i;
  logic [ADDR_W-1:0] pc_o;
  logic [DATA_W-1:0] inst_o;

  modport master (
    input  redirect_valid_i, redirect_pc_i, imem_req_ready_i,
           imem_resp_valid_i, imem_resp_data_i, ready_i,
    output imem_req_valid_o, imem_req_addr_o, valid_o, pc_o, inst_o
  );

  modport slave (
    output redirect_valid_i, redirect_pc_i, imem_req_ready_i,
           imem_resp_valid_i, imem_resp_data_i, ready_i,
    input  imem_req_valid_o, imem_req_addr_o, valid_o, pc_o, inst_o
  );
endinterface

// File: rtl/ifu_perf_cnt.sv
// ifu_perf_cnt: fetch-stage performance counters (used when IFU_PERF_EN is defined).
//   clk, rst   - clock, synchronous active-high reset (clears both counters)
//   fetch_inc  - one instruction handed to decode this cycle
//   stall_inc  - fetch waiting on memory this cycle
//   fetch_cnt, stall_cnt - free-running 32-bit counts, wrap at 2^32
module ifu_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fetch_inc) fetch_cnt <= fetch_cnt + 32'd1;
      if (stall_inc) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: NPC instruction fetch stage. Holds the PC, issues one imem read at
// a time, buffers the word and presents {pc, inst} to decode.
//   clk, rst - clock, synchronous active-high reset
//   fif      - ifu_fetch_if.master (redirect, imem request/response, decode handshake)
//   perf_fetch_cnt_o, perf_stall_cnt_o - only when IFU_PERF_EN is defined
// Optional feature macro: IFU_PERF_EN (adds ifu_perf_cnt and the two perf ports).
// Non-pipelined: one instruction every 3 cycles with a zero-wait memory.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
  input  logic        clk,
  input  logic        rst,
  ifu_fetch_if.master fif
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_stall_cnt_o
`endif
);

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              drop_q, drop_d;

  logic              redir, resp;
  logic [ADDR_W-1:0] redir_pc;
  logic              req_vld, req_fire, out_vld, out_fire;

  assign redir    = fif.redirect_valid_i;
  assign redir_pc = fif.redirect_pc_i & ~ADDR_W'(3);
  assign resp     = fif.imem_resp_valid_i;

  // Outputs are pure state decode; rst only forces the quiet reset-cycle view.
  assign req_vld  = !rst && (state_q == S_REQ);
  assign req_fire = req_vld && fif.imem_req_ready_i;
  assign out_vld  = !rst && (state_q == S_OUT);
  assign out_fire = out_vld && fif.ready_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    drop_d  = drop_q;
    case (state_q)
      S_REQ: begin
        if (req_fire) state_d = S_WAIT;
        // Stale response from a request abandoned by reset: swallow it here.
        if (resp && drop_q) drop_d = 1'b0;
        if (redir) begin
          pc_d = redir_pc;
          // Request already left with the old PC; its data must be discarded.
          if (req_fire) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (resp) begin
          if (drop_q || redir) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            inst_d  = fif.imem_resp_data_i;
            state_d = S_OUT;
          end
        end
        if (redir) begin
          pc_d = redir_pc;
          if (!resp) drop_d = 1'b1;
        end
      end
      S_OUT: begin
        // Redirect wins over pc+4 even if decode took the word this cycle.
        if (redir) begin
          pc_d    = redir_pc;
          state_d = S_REQ;
        end else if (out_fire) begin
          pc_d    = pc_q + ADDR_W'(PC_STEP);
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= DATA_W'(INST_NOP_WORD);
      // A request still in flight at reset will answer later; mark it stale.
      drop_q  <= (state_q == S_WAIT) && !resp;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      drop_q  <= drop_d;
    end
  end

  assign fif.imem_req_valid_o = req_vld;
  assign fif.imem_req_addr_o  = pc_q;
  assign fif.valid_o          = out_vld;
  assign fif.pc_o             = rst ? RESET_PC : pc_q;
  assign fif.inst_o           = rst ? DATA_W'(INST_NOP_WORD) : inst_q;

`ifdef IFU_PERF_EN
  logic stall_inc;
  assign stall_inc = !rst && ((state_q == S_REQ) || (state_q == S_WAIT)) && !redir;

  ifu_perf_cnt u_perf (
    .clk       (clk),
    .rst       (rst),
    .fetch_inc (out_fire),
    .stall_inc (stall_inc),
    .fetch_cnt (perf_fetch_cnt_o),
    .stall_cnt (perf_stall_cnt_o)
  );
`endif

endmodule
